// File: rtl/stopwatch_bcd_chain.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_bcd_chain
// Purpose  : Multi-digit BCD stopwatch/timer with prescaler, up/down, preset
//            load, lap snapshot and expiry detection, all in the clk domain.
// Revision : 1.0
// ============================================================================
module stopwatch_bcd_chain #(
    parameter int              CLK_DIV  = 500000,
    parameter int              NDIG     = 4,
    parameter logic [NDIG-1:0] SIX_MASK = 4'b1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              clear,
    input  logic              up_down,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              lap,
    output logic [4*NDIG-1:0] count,
    output logic [4*NDIG-1:0] disp,
    output logic              tick,
    output logic              wrap,
    output logic              expired,
    output logic              lap_active
);

    localparam int            PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
    localparam int            W    = 4 * NDIG;

    logic [PW-1:0] r_presc;
    logic [W-1:0]  r_count;
    logic [W-1:0]  r_snap;
    logic          r_lap_q;
    logic          r_lap_active;
    logic          r_tick;
    logic          r_wrap;
    logic          r_expired;

    logic [NDIG:0] w_chain;
    logic [W-1:0]  w_next;
    logic [W-1:0]  w_load;
    logic          w_step;
    logic          w_all_zero;
    logic          w_all_max;
    logic          w_lap_rise;

    assign w_step     = run && (r_presc == PMAX);
    assign w_lap_rise = lap && !r_lap_q;
    assign w_chain[0] = 1'b1;

    // Carry/borrow ripples through each digit that sits at its limit.
    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_digit
            localparam logic [3:0] DMAX = SIX_MASK[i] ? 4'd5 : 4'd9;
            logic [3:0] w_d;
            logic [3:0] w_lv;
            logic       w_at_max;
            logic       w_at_zero;

            assign w_d       = r_count[4*i +: 4];
            assign w_lv      = load_val[4*i +: 4];
            assign w_at_max  = (w_d == DMAX);
            assign w_at_zero = (w_d == 4'd0);

            assign w_chain[i+1] = w_chain[i] & (up_down ? w_at_max : w_at_zero);

            assign w_next[4*i +: 4] = !w_chain[i] ? w_d :
                                      up_down     ? (w_at_max  ? 4'd0 : w_d + 4'd1) :
                                                    (w_at_zero ? DMAX : w_d - 4'd1);

            assign w_load[4*i +: 4] = (w_lv > DMAX) ? DMAX : w_lv;
        end
    endgenerate

    assign w_all_zero = (r_count == '0);
    assign w_all_max  = up_down && w_chain[NDIG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc      <= '0;
            r_count      <= '0;
            r_snap       <= '0;
            r_lap_q      <= 1'b0;
            r_lap_active <= 1'b0;
            r_tick       <= 1'b0;
            r_wrap       <= 1'b0;
            r_expired    <= 1'b0;
        end else begin
            r_lap_q <= lap;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            if (clear) begin
                r_count      <= '0;
                r_presc      <= '0;
                r_lap_active <= 1'b0;
                r_expired    <= 1'b0;
            end else begin
                // Snapshot takes the pre-step value when a lap edge meets a step.
                if (w_lap_rise) begin
                    if (!r_lap_active)
                        r_snap <= r_count;
                    r_lap_active <= !r_lap_active;
                end
                if (load) begin
                    r_count   <= w_load;
                    r_presc   <= '0;
                    r_expired <= 1'b0;
                end else if (run) begin
                    if (w_step) begin
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                        if (up_down) begin
                            r_count <= w_next;
                            r_wrap  <= w_all_max;
                        end else if (w_all_zero) begin
                            r_expired <= 1'b1;
                        end else begin
                            r_count <= w_next;
                            if (w_next == '0)
                                r_expired <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
            end
        end
    end

    assign count      = r_count;
    assign disp       = r_lap_active ? r_snap : r_count;
    assign tick       = r_tick;
    assign wrap       = r_wrap;
    assign expired    = r_expired;
    assign lap_active = r_lap_active;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_bcd_chain
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random stimulus against an integer-valued reference model.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_bcd_chain;

    localparam int CLK_DIV = 3;
    localparam int NDIG    = 4;
    localparam int MODULUS = 6000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        up_down = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic        lap = 1'b0;
    logic [15:0] count;
    logic [15:0] disp;
    logic        tick;
    logic        wrap;
    logic        expired;
    logic        lap_active;

    int checks = 0;
    int errors = 0;

    stopwatch_bcd_chain #(
        .CLK_DIV  (CLK_DIV),
        .NDIG     (NDIG),
        .SIX_MASK (4'b1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .up_down    (up_down),
        .load       (load),
        .load_val   (load_val),
        .lap        (lap),
        .count      (count),
        .disp       (disp),
        .tick       (tick),
        .wrap       (wrap),
        .expired    (expired),
        .lap_active (lap_active)
    );

    always #5 clk = ~clk;

    // Reference model: the time value held as a plain integer 0..5999.
    int m_val, m_ph, m_snap;
    bit m_lap_act, m_lapq, m_tick, m_wrap, m_exp;

    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]) + 1000 * int'(b[15:12]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] b;
        b[3:0]   = 4'(v % 10);
        b[7:4]   = 4'((v / 10) % 10);
        b[11:8]  = 4'((v / 100) % 10);
        b[15:12] = 4'(v / 1000);
        return b;
    endfunction

    function automatic int clamp_load(input logic [15:0] lv);
        logic [15:0] c;
        logic [3:0]  dg;
        for (int d = 0; d < 4; d++) begin
            dg = lv[4*d +: 4];
            if (d == 3 && dg > 4'd5) dg = 4'd5;
            if (d != 3 && dg > 4'd9) dg = 4'd9;
            c[4*d +: 4] = dg;
        end
        return bcd2int(c);
    endfunction

    task automatic model_reset();
        m_val = 0; m_ph = 0; m_snap = 0;
        m_lap_act = 0; m_lapq = 0; m_tick = 0; m_wrap = 0; m_exp = 0;
    endtask

    task automatic model_edge();
        bit rise;
        rise   = lap && !m_lapq;
        m_lapq = lap;
        m_tick = 0;
        m_wrap = 0;
        if (clear) begin
            m_val = 0; m_ph = 0; m_lap_act = 0; m_exp = 0;
        end else begin
            if (rise) begin
                if (!m_lap_act) m_snap = m_val;
                m_lap_act = !m_lap_act;
            end
            if (load) begin
                m_val = clamp_load(load_val); m_ph = 0; m_exp = 0;
            end else if (run) begin
                if (m_ph == CLK_DIV - 1) begin
                    m_ph   = 0;
                    m_tick = 1;
                    if (up_down) begin
                        m_wrap = (m_val == MODULUS - 1);
                        m_val  = (m_val + 1) % MODULUS;
                    end else begin
                        if (m_val <= 1) m_exp = 1;
                        if (m_val > 0) m_val = m_val - 1;
                    end
                end else begin
                    m_ph = m_ph + 1;
                end
            end
        end
    endtask

    int shown = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (shown < 40)
                $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
            shown++;
        end
    endtask

    task automatic compare_all();
        chk("count",      32'(count),      32'(int2bcd(m_val)));
        chk("disp",       32'(disp),       32'(int2bcd(m_lap_act ? m_snap : m_val)));
        chk("tick",       32'(tick),       32'(m_tick));
        chk("wrap",       32'(wrap),       32'(m_wrap));
        chk("expired",    32'(expired),    32'(m_exp));
        chk("lap_active", 32'(lap_active), 32'(m_lap_act));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    typedef struct {
        logic [15:0] lv;
        logic        up;
        logic [15:0] exp_load;
        logic [15:0] exp_step;
        logic        exp_wrap;
        logic        exp_expired;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h0059, 1'b1, 16'h0059, 16'h0060, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 1'b1, 16'h5999, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0002, 1'b0, 16'h0002, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'h1000, 1'b0, 16'h1000, 16'h0999, 1'b0, 1'b0};
        vecs[5] = '{16'h0C0C, 1'b1, 16'h0909, 16'h0910, 1'b0, 1'b0};
        vecs[6] = '{16'h7A5B, 1'b0, 16'h5959, 16'h5958, 1'b0, 1'b0};
        vecs[7] = '{16'h0001, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_disp",  32'(disp),  32'h0);

        // Free run from reset through a full 0000..5999 rollover.
        run = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 3 * MODULUS; i++) begin
            cycle();
            if (i == 3)      chk("first_tick", 32'(tick), 32'h1);
            if (i == 30)     chk("ten_ticks", 32'(count), 32'h0010);
            if (i == 17997)  chk("all_max", 32'(count), 32'h5999);
            if (i == 18000) begin
                chk("rollover_count", 32'(count), 32'h0000);
                chk("rollover_wrap",  32'(wrap),  32'h1);
            end
        end

        // Load-then-single-step vectors.
        run = 1'b0;
        foreach (vecs[v]) begin
            load = 1'b1; load_val = vecs[v].lv; up_down = vecs[v].up;
            cycle();
            chk("vec_load", 32'(count), 32'(vecs[v].exp_load));
            load = 1'b0; run = 1'b1;
            cycles(3);
            chk("vec_step",    32'(count),   32'(vecs[v].exp_step));
            chk("vec_tick",    32'(tick),    32'h1);
            chk("vec_wrap",    32'(wrap),    32'(vecs[v].exp_wrap));
            chk("vec_expired", 32'(expired), 32'(vecs[v].exp_expired));
            run = 1'b0;
        end

        // Countdown to zero, hold at zero, clear releases expiry.
        clear = 1'b1; cycle(); clear = 1'b0;
        load = 1'b1; load_val = 16'h0002; up_down = 1'b0; cycle(); load = 1'b0;
        run = 1'b1;
        cycles(6);
        chk("down_zero", 32'(count), 32'h0000);
        chk("down_exp",  32'(expired), 32'h1);
        cycles(6);
        chk("hold_zero", 32'(count), 32'h0000);
        chk("hold_exp",  32'(expired), 32'h1);
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("clear_exp", 32'(expired), 32'h0);

        // Pause after one prescaler cycle; phase must be preserved.
        run = 1'b1; up_down = 1'b1;
        cycle();
        run = 1'b0;
        cycles(20);
        chk("pause_count", 32'(count), 32'h0000);
        run = 1'b1;
        cycle();
        chk("resume_no_tick", 32'(tick), 32'h0);
        cycle();
        chk("resume_tick", 32'(tick), 32'h1);
        chk("resume_count", 32'(count), 32'h0001);

        // Lap freeze at 0123, then release.
        run = 1'b0; load = 1'b1; load_val = 16'h0123; cycle(); load = 1'b0;
        lap = 1'b1; run = 1'b1; cycle();
        chk("lap_on", 32'(lap_active), 32'h1);
        cycles(30);
        chk("lap_disp",  32'(disp),  32'h0123);
        chk("lap_count", 32'(count), 32'h0133);
        lap = 1'b0; cycle();
        lap = 1'b1; cycle();
        chk("lap_off", 32'(lap_active), 32'h0);
        chk("lap_track", 32'(disp), 32'(count));
        lap = 1'b0; cycle();

        // clear and load together on a step edge.
        clear = 1'b1; cycle(); clear = 1'b0;
        cycles(2);
        clear = 1'b1; load = 1'b1; load_val = 16'h0042; cycle();
        chk("cl_count", 32'(count), 32'h0000);
        chk("cl_tick",  32'(tick),  32'h0);
        clear = 1'b0; load = 1'b0;
        cycles(2);
        chk("cl_presc_restart", 32'(tick), 32'h0);
        cycle();
        chk("cl_next_tick", 32'(tick), 32'h1);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            run      = ($urandom_range(0, 9) != 0);
            clear    = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 99) == 0);
            load_val = 16'($urandom);
            if ($urandom_range(0, 49) == 0) up_down = ~up_down;
            if ($urandom_range(0, 14) == 0) lap = ~lap;
            cycle();
        end

        // Asynchronous reset between clock edges.
        clear = 1'b0; load = 1'b0; run = 1'b1; up_down = 1'b1;
        load = 1'b1; load_val = 16'h0456; cycle(); load = 1'b0;
        lap = 1'b0; cycle(); lap = 1'b1; cycle();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("async_count", 32'(count), 32'h0);
        chk("async_lap",   32'(lap_active), 32'h0);
        @(negedge clk);
        reset = 1'b0; lap = 1'b0;
        cycles(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
